// File: rtl/bfp16_col_feeder.sv
// Weight/ifmap feeder for a DEPTH-deep bfloat16 PE column: buffers DEPTH weights and up to
// MAX_ROWS ifmap rows, preloads weights last-first, then streams rows with a per-lane diagonal skew.
module bfp16_col_feeder #(
  parameter int DATA_TYPE = 16,
  parameter int DEPTH     = 2,
  parameter int MAX_ROWS  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(MAX_ROWS+1)-1:0]    num_rows,
  input  logic                             wgt_valid,
  input  logic [DATA_TYPE-1:0]             wgt_data,
  output logic                             wgt_ready,
  input  logic                             row_valid,
  input  logic [DEPTH*DATA_TYPE-1:0]       row_data,
  output logic                             row_ready,
  output logic                             ctrl,
  output logic [DATA_TYPE-1:0]             weight,
  output logic [DEPTH*DATA_TYPE-1:0]       ifmap,
  output logic                             busy,
  output logic                             done
);
  localparam int CW = $clog2(MAX_ROWS + 1);
  localparam int WCW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(MAX_ROWS + DEPTH + 1);
  localparam int RW = DEPTH * DATA_TYPE;
  localparam logic [WCW-1:0] W_FULL = WCW'(DEPTH);
  localparam logic [CW-1:0] ROWS_MAX = CW'(MAX_ROWS);
  localparam logic [TW-1:0] PRE_LAST = TW'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, FILL, PRELOAD, STREAM, DONE} state_t;

  state_t                     state;
  logic [CW-1:0]              nrows;
  logic [WCW-1:0]             wcnt, wcnt_n;
  logic [CW-1:0]              rcnt, rcnt_n;
  logic [TW-1:0]              cnt;
  logic [TW-1:0]              t_last;
  logic [DEPTH*DATA_TYPE-1:0] wbuf;
  logic [MAX_ROWS*RW-1:0]     rbuf;
  logic                       wgt_take, row_take;
  logic [DATA_TYPE-1:0]       pre_w;
  logic [RW-1:0]              skew;
  int                         pre_idx, nxt_t;

  // Handshake: a word transfers on a rising edge where valid and ready are both high;
  // ready depends only on state and counters, never on valid.
  assign wgt_ready = (state == FILL) && (wcnt < W_FULL);
  assign row_ready = (state == FILL) && (rcnt < nrows);
  assign busy      = (state != IDLE);
  assign t_last    = TW'(nrows) + TW'(DEPTH - 1) - TW'(1);

  always_comb begin
    wgt_take = wgt_valid && wgt_ready;
    row_take = row_valid && row_ready;
    wcnt_n   = wcnt + WCW'(wgt_take);
    rcnt_n   = rcnt + CW'(row_take);
    // The first preload word may be the weight arriving on the FILL exit edge, so bypass it.
    pre_idx  = (state == FILL) ? DEPTH - 1 : DEPTH - 2 - int'(cnt);
    pre_w    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == pre_idx) begin
        pre_w = (wgt_take && wcnt == WCW'(k)) ? wgt_data : wbuf[k*DATA_TYPE +: DATA_TYPE];
      end
    end
    nxt_t = (state == STREAM) ? int'(cnt) + 1 : 0;
    skew  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      for (int r = 0; r < MAX_ROWS; r++) begin
        if (r == nxt_t - j && r < int'(nrows)) begin
          skew[(DEPTH-1-j)*DATA_TYPE +: DATA_TYPE] =
            rbuf[r*RW + (DEPTH-1-j)*DATA_TYPE +: DATA_TYPE];
        end
      end
    end
  end

  // Buffers carry no reset: the FSM never drives them out until they have been refilled.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (wgt_take && wcnt == WCW'(k)) wbuf[k*DATA_TYPE +: DATA_TYPE] <= wgt_data;
    end
    for (int r = 0; r < MAX_ROWS; r++) begin
      if (row_take && rcnt == CW'(r)) rbuf[r*RW +: RW] <= row_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      nrows  <= '0;
      wcnt   <= '0;
      rcnt   <= '0;
      cnt    <= '0;
      ctrl   <= 1'b0;
      weight <= '0;
      ifmap  <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && num_rows != '0 && num_rows <= ROWS_MAX) begin
            nrows <= num_rows;
            wcnt  <= '0;
            rcnt  <= '0;
            cnt   <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          wcnt <= wcnt_n;
          rcnt <= rcnt_n;
          if (wcnt_n == W_FULL && rcnt_n == nrows) begin
            weight <= pre_w;
            cnt    <= '0;
            state  <= PRELOAD;
          end
        end
        PRELOAD: begin
          if (cnt == PRE_LAST) begin
            ctrl   <= 1'b1;
            weight <= '0;
            ifmap  <= skew;
            cnt    <= '0;
            state  <= STREAM;
          end else begin
            weight <= pre_w;
            cnt    <= cnt + TW'(1);
          end
        end
        STREAM: begin
          if (cnt == t_last) begin
            ctrl  <= 1'b0;
            ifmap <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            ifmap <= skew;
            cnt   <= cnt + TW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bfp16_col_feeder.md
BFP16_COL_FEEDER -- requirements
Module: bfp16_col_feeder

Interface
REQ-001 The block SHALL have these parameters:
- DATA_TYPE, default 16, element width (bfloat16).
- DEPTH, default 2, number of PEs and ifmap lanes in the downstream column.
- MAX_ROWS, default 8, maximum ifmap rows per job.
REQ-002 The block SHALL have these ports; one clock; reset is asynchronous and active-high:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  job start pulse, sampled in IDLE.
- num_rows  in  $clog2(MAX_ROWS+1)  ifmap rows in the job, sampled with start.
- wgt_valid  in  1  weight word valid.
- wgt_data  in  DATA_TYPE  weight element; element k arrives k-th.
- wgt_ready  out  1  weight word accepted when valid&ready.
- row_valid  in  1  ifmap row valid.
- row_data  in  DEPTH*DATA_TYPE  one matrix row; element 0 in the MS slice.
- row_ready  out  1  row accepted when valid&ready.
- ctrl  out  1  to column: 0 = weight preload, 1 = compute.
- weight  out  DATA_TYPE  to column weight input.
- ifmap  out  DEPTH*DATA_TYPE  to column ifmap input; lane 0 in the MS slice.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of job.

Function
REQ-003 The FSM SHALL have states IDLE, FILL, PRELOAD, STREAM, DONE.
REQ-004 In IDLE, start=1 with num_rows in 1..MAX_ROWS SHALL latch num_rows, clear counters and enter FILL; start with num_rows=0 or >MAX_ROWS SHALL be ignored.
REQ-005 start outside IDLE SHALL be ignored.
REQ-006 In FILL, wgt_ready SHALL be 1 while fewer than DEPTH weights are held, and row_ready SHALL be 1 while fewer than num_rows rows are held; both SHALL be 0 in all other states.
REQ-007 Weights and rows SHALL be accepted in the same cycle independently; accepted words SHALL be stored in arrival order.
REQ-008 FILL SHALL go to PRELOAD on the edge after the last required weight and last required row have both been accepted.
REQ-009 PRELOAD SHALL last exactly DEPTH cycles with ctrl=0, ifmap=0, and weight = w[DEPTH-1-k] in preload cycle k, so the last element goes out first.
REQ-010 STREAM SHALL last exactly num_rows+DEPTH-1 cycles with ctrl=1 and weight=0.
REQ-011 In STREAM cycle t (0-based), lane j SHALL carry row[t-j] element j when 0 <= t-j < num_rows, else 0. This is a diagonal skew of one cycle per lane.
REQ-012 After STREAM the FSM SHALL enter DONE for one cycle with done=1 and all data outputs 0, then return to IDLE.
REQ-013 ctrl, weight, ifmap and done SHALL be registered outputs, so values listed for a state appear on the edge entering that state's cycle.
REQ-014 In IDLE, FILL and DONE, ctrl SHALL be 0, weight 0 and ifmap 0.
REQ-015 Storage SHALL be MAX_ROWS x DEPTH*DATA_TYPE for rows plus DEPTH x DATA_TYPE for weights; data SHALL pass through bit-exact with no arithmetic.
REQ-016 Words offered beyond the required counts SHALL NOT be accepted, since ready is deasserted.

Reset
REQ-017 While rst=1, regardless of clock, the FSM SHALL be IDLE and ctrl, weight, ifmap, wgt_ready, row_ready, busy and done SHALL all be 0.
REQ-018 Reset mid-job SHALL discard all buffered weights and rows; the next job SHALL require a fresh start.
REQ-019 Buffer contents are don't-care after reset; no output SHALL expose stale data.

Verification
REQ-020 Nominal case, matching the column's 4x2 test:
- Stimulus: weights 3F80 then 449B; 4 rows of {4040,4100}; num_rows=4.
- Response: PRELOAD weight 449B, then 3F80, with ctrl=0.
- Then 5 STREAM cycles with ctrl=1 and ifmap = {4040,0000}, {4040,4100} x3, {0000,4100}.
- Then done=1 for one cycle.
REQ-021 Single row: num_rows=1 with row {3F80,4000} -> 2 STREAM cycles: {3F80,0000}, {0000,4000}.
REQ-022 Full buffer: num_rows=8 with rows interleaved with weights and random valid gaps -> row_ready drops after the 8th row; STREAM lasts 9 cycles with correct skew.
REQ-023 Illegal start: start with num_rows=0, and start during STREAM -> no state change, busy unchanged.
REQ-024 Reset during STREAM cycle 2 -> all outputs 0 immediately (asynchronous); a subsequent job runs correctly from start.
